// File: rtl/sid_voice_dca.sv
// SID voice DCA: signed (wav - 0x800) times unsigned envelope, iterative shift-add, start/busy/valid.
// Build option: define SID_DCA_ROUND_EN for round-half-up scaling instead of floor truncation.
module sid_voice_dca #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int OUT_BITS       = 16
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic [11:0]         wav,
    input  logic [7:0]          env,
    output logic                busy,
    output logic                valid,
    output logic [OUT_BITS-1:0] out
);
    localparam int         N    = 8 / BITS_PER_CYCLE;
    localparam logic [3:0] LAST = 4'(N - 1);
`ifdef SID_DCA_ROUND_EN
    localparam int                RND_SH = (OUT_BITS < 20) ? 19 - OUT_BITS : 0;
    localparam logic signed [19:0] RND   = (OUT_BITS < 20) ? (20'sd1 <<< RND_SH) : 20'sd0;
`else
    localparam logic signed [19:0] RND   = 20'sd0;
`endif

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
        $error("sid_voice_dca: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if (OUT_BITS < 12 || OUT_BITS > 20) begin : g_bad_out_bits
        $error("sid_voice_dca: OUT_BITS must be in 12..20");
    end

    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [OUT_BITS-1:0] out_q, out_d;
    logic signed [19:0]  acc_q, acc_d;
    logic signed [19:0]  a_sh_q, a_sh_d;
    logic [7:0]          m_q, m_d;
    logic [3:0]          cnt_q, cnt_d;
    logic signed [19:0]  acc_step;
    logic signed [19:0]  rounded;

    // NOTE: always_comb uses blocking '=' so acc_step accumulates within the loop;
    // state registers below use '<=' only.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        busy_d   = busy_q;
        valid_d  = 1'b0;
        out_d    = out_q;
        acc_d    = acc_q;
        a_sh_d   = a_sh_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        acc_step = acc_q;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (m_q[j]) acc_step = acc_step + (a_sh_q <<< j);
        end
        rounded = acc_step + RND;

        if (busy_q) begin
            acc_d  = acc_step;
            a_sh_d = a_sh_q <<< BITS_PER_CYCLE;
            m_d    = m_q >> BITS_PER_CYCLE;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == LAST) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                out_d   = OUT_BITS'(rounded >>> (20 - OUT_BITS));
            end
        end

        // The finishing edge can also accept, giving one result every N clocks.
        if (start && (!busy_q || cnt_q == LAST)) begin
            busy_d = 1'b1;
            acc_d  = '0;
            a_sh_d = {{9{~wav[11]}}, wav[10:0]};
            m_d    = env;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
            acc_q   <= '0;
            a_sh_q  <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign out   = out_q;
endmodule

// File: tb/tb_sid_voice_dca.sv
// Scoreboard bench for sid_voice_dca: default build (N=8, 16-bit out) plus an N=1, 20-bit instance.
module tb_sid_voice_dca;
    typedef struct {
        int val;
        int done;
    } exp_t;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0, start8 = 1'b0;
    logic [11:0] wav = '0, wav8 = '0;
    logic [7:0]  env = '0, env8 = '0;
    logic        busy, valid, busy8, valid8;
    logic [15:0] out;
    logic [19:0] out8;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t q16[$];
    exp_t q20[$];
    int   done16 = 0;
    int   done20 = 0;

    sid_voice_dca u_dut (
        .clk(clk), .res(res), .start(start), .wav(wav), .env(env),
        .busy(busy), .valid(valid), .out(out)
    );

    sid_voice_dca #(.BITS_PER_CYCLE(8), .OUT_BITS(20)) u_dut8 (
        .clk(clk), .res(res), .start(start8), .wav(wav8), .env(env8),
        .busy(busy8), .valid(valid8), .out(out8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: exact signed product, then scale to 16 bits by floor or round-half-up.
    function automatic int product(input logic [11:0] w, input logic [7:0] e);
        return (int'(w) - 2048) * int'(e);
    endfunction

    function automatic int model16(input logic [11:0] w, input logic [7:0] e);
        int p = product(w, e);
`ifdef SID_DCA_ROUND_EN
        return (p + 8) >>> 4;
`else
        return p >>> 4;
`endif
    endfunction

    function automatic logic [11:0] pick_wav();
        case ($urandom % 6)
            0: return 12'h000;
            1: return 12'hFFF;
            2: return 12'h800;
            default: return 12'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick_env();
        case ($urandom % 6)
            0: return 8'h00;
            1: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor: samples at the falling edge, compares against the scoreboard heads.
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        check("busy16", int'(busy), int'(done16 > cyc));
        ev = q16.size() > 0 && q16[0].done == cyc;
        check("valid16", int'(valid), int'(ev));
        if (ev) begin
            e = q16.pop_front();
            if (valid) check("out16", int'($signed(out)), e.val);
        end
        check("busy20", int'(busy8), int'(done20 > cyc));
        ev = q20.size() > 0 && q20[0].done == cyc;
        check("valid20", int'(valid8), int'(ev));
        if (ev) begin
            e = q20.pop_front();
            if (valid8) check("out20", int'($signed(out8)), e.val);
        end
    end

    // Drive one cycle of the N=8 instance; predict acceptance from the outstanding job's end edge.
    task automatic drive16(input bit s, input logic [11:0] w, input logic [7:0] e);
        @(negedge clk);
        #1;
        start = s;
        wav   = w;
        env   = e;
        if (s && done16 <= cyc + 1) begin
            done16 = cyc + 1 + 8;
            q16.push_back('{val: model16(w, e), done: done16});
        end
    endtask

    task automatic drive20(input bit s, input logic [11:0] w, input logic [7:0] e);
        @(negedge clk);
        #1;
        start8 = s;
        wav8   = w;
        env8   = e;
        if (s && done20 <= cyc + 1) begin
            done20 = cyc + 2;
            q20.push_back('{val: product(w, e), done: done20});
        end
    endtask

    task automatic idle16(input int n);
        for (int i = 0; i < n; i++) drive16(1'b0, pick_wav(), pick_env());
    endtask

    initial begin
        #3;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_out", int'(out), 0);
        @(negedge clk);
        #1 res = 1'b0;

        drive16(1'b1, 12'hFFF, 8'hFF); idle16(10);
        drive16(1'b1, 12'h000, 8'hFF); idle16(10);
        drive16(1'b1, 12'h800, 8'hA5); idle16(10);
        drive16(1'b1, 12'hFFF, 8'h00); idle16(10);
        drive16(1'b1, 12'h801, 8'h0F); idle16(10);

        // Overlap: B requested 3 clocks into A and held until it is taken on A's final edge.
        drive16(1'b1, 12'hFFF, 8'hFF);
        idle16(2);
        for (int i = 0; i < 6; i++) drive16(1'b1, 12'h000, 8'hFF);
        idle16(10);
        check("overlap_drained", q16.size(), 0);

        // Asynchronous reset four clocks into a multiplication.
        drive16(1'b1, 12'h123, 8'hC7);
        idle16(3);
        @(posedge clk);
        #2 res = 1'b1;
        q16.delete();
        done16 = 0;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(valid), 0);
        check("midreset_out", int'(out), 0);
        idle16(2);
        res = 1'b0;
        idle16(20);

        for (int i = 0; i < 400; i++) drive16(($urandom % 3) == 0, pick_wav(), pick_env());
        idle16(12);
        check("random_drained", q16.size(), 0);

        // N=1 instance: a new request on every clock.
        for (int i = 0; i < 60; i++) drive20(1'b1, pick_wav(), pick_env());
        drive20(1'b0, 12'h0, 8'h0);
        drive20(1'b0, 12'h0, 8'h0);
        drive20(1'b0, 12'h0, 8'h0);
        check("n1_drained", q20.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
